// File: rtl/pentary_issue_scheduler.sv
// Issue scheduler: per-register scoreboard, RAW/WAW and busy-unit stalls, and a single writeback port shared by ALU, LSU and MVU.
// Optional performance counters are enabled by defining PENTARY_SCHED_PERF_EN.
module pentary_issue_scheduler #(
    parameter int NUM_REGS    = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int MVU_TIMEOUT = 1024
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  flush,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [REG_ADDR_W-1:0] dec_rd,
    input  logic [REG_ADDR_W-1:0] dec_rs1,
    input  logic [REG_ADDR_W-1:0] dec_rs2,
    input  logic                  dec_rs1_used,
    input  logic                  dec_rs2_used,
    input  logic                  dec_reg_write,
    input  logic                  dec_mem_read,
    input  logic                  dec_mem_write,
    input  logic                  dec_memristor_op,
    output logic                  alu_issue,
    output logic                  lsu_issue,
    output logic                  mvu_issue,
    output logic [REG_ADDR_W-1:0] issue_rd,
    input  logic                  lsu_done,
    input  logic                  mvu_done,
    output logic                  lsu_done_ack,
    output logic                  mvu_done_ack,
    output logic                  wb_en,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            wb_sel,
    output logic [NUM_REGS-1:0]   sb_pending,
    output logic                  timeout_err
`ifdef PENTARY_SCHED_PERF_EN
    ,
    output logic [31:0]           stall_hazard_cnt,
    output logic [31:0]           stall_struct_cnt,
    output logic [31:0]           issue_cnt
`endif
);

    localparam int CNT_W = $clog2(MVU_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(MVU_TIMEOUT - 1);

    logic                  w_is_mvu, w_is_lsu, w_is_alu;
    logic                  w_hazard, w_busy, w_drain, w_issue;
    logic                  w_lsu_cmp, w_mvu_cmp;
    logic [NUM_REGS-1:0]   w_set, w_clr;

    logic [NUM_REGS-1:0]   r_pending;
    logic                  r_lsu_busy, r_lsu_we, r_mvu_busy, r_mvu_we;
    logic [REG_ADDR_W-1:0] r_lsu_rd, r_mvu_rd, r_alu_rd;
    logic                  r_alu_wb;
    logic                  r_to_run, r_to_err;
    logic [CNT_W-1:0]      r_to_cnt;

    // Only completions from a unit with an outstanding operation are real.
    always_comb begin
        w_is_mvu  = dec_memristor_op;
        w_is_lsu  = !dec_memristor_op && (dec_mem_read || dec_mem_write);
        w_is_alu  = !w_is_mvu && !w_is_lsu;
        w_lsu_cmp = lsu_done && r_lsu_busy;
        w_mvu_cmp = mvu_done && r_mvu_busy;
        w_hazard  = (dec_rs1_used && r_pending[dec_rs1]) ||
                    (dec_rs2_used && r_pending[dec_rs2]) ||
                    (dec_reg_write && (dec_rd != '0) && r_pending[dec_rd]);
        w_busy    = (w_is_lsu && r_lsu_busy) || (w_is_mvu && r_mvu_busy);
        w_drain   = w_is_alu && dec_reg_write && (w_lsu_cmp || w_mvu_cmp);
        dec_ready = reset_n && !flush && !w_hazard && !w_busy && !w_drain;
        w_issue   = dec_valid && dec_ready;
        alu_issue = w_issue && w_is_alu;
        lsu_issue = w_issue && w_is_lsu;
        mvu_issue = w_issue && w_is_mvu;
        issue_rd  = w_issue ? dec_rd : '0;
    end

    always_comb begin
        wb_en        = 1'b0;
        wb_rd        = '0;
        wb_sel       = 2'd0;
        lsu_done_ack = 1'b0;
        mvu_done_ack = 1'b0;
        if (r_alu_wb) begin
            wb_en = 1'b1;
            wb_rd = r_alu_rd;
        end else if (w_lsu_cmp) begin
            lsu_done_ack = 1'b1;
            wb_en        = r_lsu_we;
            wb_rd        = r_lsu_rd;
            wb_sel       = 2'd1;
        end else if (w_mvu_cmp) begin
            mvu_done_ack = 1'b1;
            wb_en        = r_mvu_we;
            wb_rd        = r_mvu_rd;
            wb_sel       = 2'd2;
        end
    end

    // r0 is never tracked; WAW stalls guarantee set and clear never hit the same bit.
    always_comb begin
        w_set = '0;
        w_clr = '0;
        if (w_issue && dec_reg_write && (dec_rd != '0)) w_set[dec_rd] = 1'b1;
        if (wb_en) w_clr[wb_rd] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pending  <= '0;
            r_alu_wb   <= 1'b0;
            r_alu_rd   <= '0;
            r_lsu_busy <= 1'b0;
            r_lsu_we   <= 1'b0;
            r_lsu_rd   <= '0;
            r_mvu_busy <= 1'b0;
            r_mvu_we   <= 1'b0;
            r_mvu_rd   <= '0;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_set;
            r_alu_wb  <= alu_issue && dec_reg_write;
            r_alu_rd  <= dec_rd;
            if (lsu_issue) begin
                r_lsu_busy <= 1'b1;
                r_lsu_we   <= dec_reg_write;
                r_lsu_rd   <= dec_rd;
            end else if (lsu_done_ack) begin
                r_lsu_busy <= 1'b0;
            end
            if (mvu_issue) begin
                r_mvu_busy <= 1'b1;
                r_mvu_we   <= dec_reg_write;
                r_mvu_rd   <= dec_rd;
            end else if (mvu_done_ack) begin
                r_mvu_busy <= 1'b0;
            end
        end
    end

    // r_to_cnt holds the number of cycles elapsed since the MVU issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_to_run <= 1'b0;
            r_to_cnt <= '0;
            r_to_err <= 1'b0;
        end else if (mvu_issue) begin
            r_to_run <= 1'b1;
            r_to_cnt <= CNT_W'(1);
            if (TO_LAST == '0) r_to_err <= 1'b1;
        end else if (mvu_done_ack) begin
            r_to_run <= 1'b0;
        end else if (r_to_run) begin
            if (r_to_cnt >= TO_LAST) begin
                r_to_err <= 1'b1;
                r_to_run <= 1'b0;
            end else begin
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            end
        end
    end

    assign sb_pending  = r_pending;
    assign timeout_err = r_to_err;

`ifdef PENTARY_SCHED_PERF_EN
    logic [31:0] r_hz_cnt, r_st_cnt, r_is_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hz_cnt <= '0;
            r_st_cnt <= '0;
            r_is_cnt <= '0;
        end else begin
            if (dec_valid && w_hazard && (r_hz_cnt != '1)) r_hz_cnt <= r_hz_cnt + 32'd1;
            if (dec_valid && !w_hazard && !dec_ready && (r_st_cnt != '1)) r_st_cnt <= r_st_cnt + 32'd1;
            if (w_issue && (r_is_cnt != '1)) r_is_cnt <= r_is_cnt + 32'd1;
        end
    end

    assign stall_hazard_cnt = r_hz_cnt;
    assign stall_struct_cnt = r_st_cnt;
    assign issue_cnt        = r_is_cnt;
`endif

endmodule

// File: tb/tb_pentary_issue_scheduler.sv
// Directed bench for pentary_issue_scheduler with MVU_TIMEOUT shortened to 16.
module tb_pentary_issue_scheduler;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       flush = 1'b0;
    logic       dec_valid, dec_ready;
    logic [4:0] dec_rd, dec_rs1, dec_rs2;
    logic       dec_rs1_used, dec_rs2_used, dec_reg_write;
    logic       dec_mem_read, dec_mem_write, dec_memristor_op;
    logic       alu_issue, lsu_issue, mvu_issue;
    logic [4:0] issue_rd;
    logic       lsu_done = 1'b0, mvu_done = 1'b0;
    logic       lsu_done_ack, mvu_done_ack;
    logic       wb_en;
    logic [4:0] wb_rd;
    logic [1:0] wb_sel;
    logic [31:0] sb_pending;
    logic       timeout_err;

    int checks = 0;
    int errors = 0;

    pentary_issue_scheduler #(.NUM_REGS(32), .REG_ADDR_W(5), .MVU_TIMEOUT(16)) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .dec_rd(dec_rd), .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
        .dec_rs1_used(dec_rs1_used), .dec_rs2_used(dec_rs2_used),
        .dec_reg_write(dec_reg_write), .dec_mem_read(dec_mem_read),
        .dec_mem_write(dec_mem_write), .dec_memristor_op(dec_memristor_op),
        .alu_issue(alu_issue), .lsu_issue(lsu_issue), .mvu_issue(mvu_issue),
        .issue_rd(issue_rd), .lsu_done(lsu_done), .mvu_done(mvu_done),
        .lsu_done_ack(lsu_done_ack), .mvu_done_ack(mvu_done_ack),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_sel(wb_sel),
        .sb_pending(sb_pending), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                         input logic u1, input logic u2, input logic rw,
                         input logic mr, input logic mw, input logic mo);
        dec_valid = v; dec_rd = rd; dec_rs1 = rs1; dec_rs2 = rs2;
        dec_rs1_used = u1; dec_rs2_used = u2; dec_reg_write = rw;
        dec_mem_read = mr; dec_mem_write = mw; dec_memristor_op = mo;
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %0b exp 0", dec_ready); end
        checks++; if (alu_issue !== 1'b0) begin errors++; $display("FAIL rst_alu_issue got %0b exp 0", alu_issue); end
        checks++; if (wb_en !== 1'b0) begin errors++; $display("FAIL rst_wb_en got %0b exp 0", wb_en); end
        checks++; if (wb_sel !== 2'd0) begin errors++; $display("FAIL rst_wb_sel got %0d exp 0", wb_sel); end
        checks++; if (sb_pending !== 32'd0) begin errors++; $display("FAIL rst_sb got %0h exp 0", sb_pending); end
        checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_timeout got %0b exp 0", timeout_err); end
        idle();
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    task automatic test_raw();
        drive(1'b1, 5'd3, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (alu_issue !== 1'b1) begin errors++; $display("FAIL raw_add_issue got %0b exp 1", alu_issue); end
        checks++; if (issue_rd !== 5'd3) begin errors++; $display("FAIL raw_issue_rd got %0d exp 3", issue_rd); end
        tick();
        drive(1'b1, 5'd4, 5'd3, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL raw_stall got %0b exp 0", dec_ready); end
        checks++; if (sb_pending[3] !== 1'b1) begin errors++; $display("FAIL raw_sb3_set got %0b exp 1", sb_pending[3]); end
        checks++; if ({wb_en, wb_sel, wb_rd} !== {1'b1, 2'd0, 5'd3}) begin errors++; $display("FAIL raw_alu_wb got en=%0b sel=%0d rd=%0d exp 1/0/3", wb_en, wb_sel, wb_rd); end
        tick();
        #1;
        checks++; if (alu_issue !== 1'b1) begin errors++; $display("FAIL raw_sub_issue got %0b exp 1", alu_issue); end
        checks++; if (sb_pending[3] !== 1'b0) begin errors++; $display("FAIL raw_sb3_clr got %0b exp 0", sb_pending[3]); end
        tick();
        idle();
        #1;
        checks++; if ({wb_en, wb_rd} !== {1'b1, 5'd4}) begin errors++; $display("FAIL raw_sub_wb got en=%0b rd=%0d exp 1/4", wb_en, wb_rd); end
        tick();
        checks++; if (sb_pending !== 32'd0) begin errors++; $display("FAIL raw_sb_final got %0h exp 0", sb_pending); end
    endtask

    task automatic test_r0();
        drive(1'b1, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (alu_issue !== 1'b1) begin errors++; $display("FAIL r0_issue got %0b exp 1", alu_issue); end
        tick();
        drive(1'b1, 5'd6, 5'd0, 5'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (sb_pending !== 32'd0) begin errors++; $display("FAIL r0_sb got %0h exp 0", sb_pending); end
        checks++; if (alu_issue !== 1'b1) begin errors++; $display("FAIL r0_reader_issue got %0b exp 1", alu_issue); end
        tick();
        idle();
        #1;
        checks++; if ({wb_en, wb_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL r0_wb6 got en=%0b rd=%0d exp 1/6", wb_en, wb_rd); end
        tick();
    endtask

    task automatic test_lsu();
        drive(1'b1, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if ({lsu_issue, alu_issue, issue_rd} !== {1'b1, 1'b0, 5'd5}) begin errors++; $display("FAIL lsu_issue got lsu=%0b alu=%0b rd=%0d exp 1/0/5", lsu_issue, alu_issue, issue_rd); end
        tick();
        drive(1'b1, 5'd6, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i < 6; i++) begin
            #1;
            checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL lsu_hold_c%0d got %0b exp 0", i, dec_ready); end
            tick();
        end
        lsu_done = 1'b1;
        #1;
        checks++; if ({lsu_done_ack, wb_en, wb_sel, wb_rd} !== {1'b1, 1'b1, 2'd1, 5'd5}) begin errors++; $display("FAIL lsu_ack got ack=%0b en=%0b sel=%0d rd=%0d exp 1/1/1/5", lsu_done_ack, wb_en, wb_sel, wb_rd); end
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL lsu_ack_hold got %0b exp 0", dec_ready); end
        tick();
        lsu_done = 1'b0;
        #1;
        checks++; if ({lsu_issue, issue_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL lsu_second_issue got %0b rd=%0d exp 1/6", lsu_issue, issue_rd); end
        checks++; if (sb_pending[5] !== 1'b0) begin errors++; $display("FAIL lsu_sb5_clr got %0b exp 0", sb_pending[5]); end
        tick();
        idle();
        lsu_done = 1'b1;
        #1;
        checks++; if ({lsu_done_ack, wb_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL lsu_ack2 got ack=%0b rd=%0d exp 1/6", lsu_done_ack, wb_rd); end
        tick();
        lsu_done = 1'b0;
        drive(1'b1, 5'd0, 5'd1, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
        #1;
        checks++; if (lsu_issue !== 1'b1) begin errors++; $display("FAIL store_issue got %0b exp 1", lsu_issue); end
        tick();
        idle();
        lsu_done = 1'b1;
        #1;
        checks++; if ({lsu_done_ack, wb_en} !== {1'b1, 1'b0}) begin errors++; $display("FAIL store_ack got ack=%0b en=%0b exp 1/0", lsu_done_ack, wb_en); end
        tick();
        lsu_done = 1'b0;
        #1;
        checks++; if (sb_pending !== 32'd0) begin errors++; $display("FAIL lsu_sb_final got %0h exp 0", sb_pending); end
    endtask

    task automatic test_arb();
        drive(1'b1, 5'd7, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (mvu_issue !== 1'b1) begin errors++; $display("FAIL arb_mvu_issue got %0b exp 1", mvu_issue); end
        tick();
        drive(1'b1, 5'd8, 5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        checks++; if (lsu_issue !== 1'b1) begin errors++; $display("FAIL arb_lsu_issue got %0b exp 1", lsu_issue); end
        tick();
        drive(1'b1, 5'd9, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if (alu_issue !== 1'b1) begin errors++; $display("FAIL arb_alu_issue got %0b exp 1", alu_issue); end
        tick();
        idle();
        lsu_done = 1'b1;
        mvu_done = 1'b1;
        #1;
        checks++; if ({wb_en, wb_sel, wb_rd, lsu_done_ack, mvu_done_ack} !== {1'b1, 2'd0, 5'd9, 1'b0, 1'b0}) begin errors++; $display("FAIL arb_alu_first got en=%0b sel=%0d rd=%0d la=%0b ma=%0b exp 1/0/9/0/0", wb_en, wb_sel, wb_rd, lsu_done_ack, mvu_done_ack); end
        tick();
        drive(1'b1, 5'd10, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if ({lsu_done_ack, mvu_done_ack, wb_sel, wb_rd} !== {1'b1, 1'b0, 2'd1, 5'd8}) begin errors++; $display("FAIL arb_lsu_second got la=%0b ma=%0b sel=%0d rd=%0d exp 1/0/1/8", lsu_done_ack, mvu_done_ack, wb_sel, wb_rd); end
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL arb_drain_lsu got %0b exp 0", dec_ready); end
        tick();
        lsu_done = 1'b0;
        #1;
        checks++; if ({mvu_done_ack, wb_en, wb_sel, wb_rd} !== {1'b1, 1'b1, 2'd2, 5'd7}) begin errors++; $display("FAIL arb_mvu_third got ma=%0b en=%0b sel=%0d rd=%0d exp 1/1/2/7", mvu_done_ack, wb_en, wb_sel, wb_rd); end
        checks++; if (dec_ready !== 1'b0) begin errors++; $display("FAIL arb_drain_mvu got %0b exp 0", dec_ready); end
        tick();
        mvu_done = 1'b0;
        #1;
        checks++; if (alu_issue !== 1'b1) begin errors++; $display("FAIL arb_alu_after got %0b exp 1", alu_issue); end
        tick();
        idle();
        #1;
        checks++; if ({wb_en, wb_rd} !== {1'b1, 5'd10}) begin errors++; $display("FAIL arb_wb10 got en=%0b rd=%0d exp 1/10", wb_en, wb_rd); end
        tick();
        checks++; if ({sb_pending, timeout_err} !== {32'd0, 1'b0}) begin errors++; $display("FAIL arb_final got sb=%0h to=%0b exp 0/0", sb_pending, timeout_err); end
    endtask

    task automatic test_flush();
        flush = 1'b1;
        drive(1'b1, 5'd11, 5'd1, 5'd2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++; if ({dec_ready, alu_issue} !== 2'b00) begin errors++; $display("FAIL flush_block got ready=%0b issue=%0b exp 0/0", dec_ready, alu_issue); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if ({alu_issue, issue_rd} !== {1'b1, 5'd11}) begin errors++; $display("FAIL flush_after got %0b rd=%0d exp 1/11", alu_issue, issue_rd); end
        tick();
        idle();
        #1;
        checks++; if ({wb_en, wb_rd} !== {1'b1, 5'd11}) begin errors++; $display("FAIL flush_wb got en=%0b rd=%0d exp 1/11", wb_en, wb_rd); end
        tick();
    endtask

    task automatic test_timeout();
        drive(1'b1, 5'd12, 5'd1, 5'd0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
        #1;
        checks++; if (mvu_issue !== 1'b1) begin errors++; $display("FAIL to_issue got %0b exp 1", mvu_issue); end
        tick();
        idle();
        for (int k = 1; k < 16; k++) begin
            #1;
            checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL to_early_c%0d got %0b exp 0", k, timeout_err); end
            tick();
        end
        #1;
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_c16 got %0b exp 1", timeout_err); end
        checks++; if (sb_pending[12] !== 1'b1) begin errors++; $display("FAIL to_sb12 got %0b exp 1", sb_pending[12]); end
        tick();
        tick();
        checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL to_sticky got %0b exp 1", timeout_err); end
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if ({sb_pending, timeout_err, wb_en, dec_ready, mvu_done_ack} !== {32'd0, 4'd0}) begin errors++; $display("FAIL to_async_rst got sb=%0h to=%0b en=%0b rdy=%0b ma=%0b exp all 0", sb_pending, timeout_err, wb_en, dec_ready, mvu_done_ack); end
        tick();
        reset_n = 1'b1;
        mvu_done = 1'b1;
        #1;
        checks++; if ({mvu_done_ack, wb_en} !== 2'b00) begin errors++; $display("FAIL to_stray_done got ack=%0b en=%0b exp 0/0", mvu_done_ack, wb_en); end
        tick();
        mvu_done = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        idle();
        #3;
        test_reset();
        test_raw();
        test_r0();
        test_lsu();
        test_arb();
        test_flush();
        test_timeout();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
